// File: rtl/traffic_control_unit_pkg.sv
// Shared definitions for the traffic control unit: direction codes, FSM state
// encodings, light codes and the duration-counter width.
package traffic_defs;

  localparam logic [1:0] DIR_N = 2'd0;
  localparam logic [1:0] DIR_E = 2'd1;
  localparam logic [1:0] DIR_S = 2'd2;
  localparam logic [1:0] DIR_W = 2'd3;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_GREEN = 2'd1,
    ST_EMG   = 2'd2
  } state_t;

  localparam logic [1:0] LIGHT_GREEN = 2'b01;
  localparam logic [1:0] LIGHT_RED   = 2'b10;

  localparam int TIMER_W = 8;

  function automatic logic [1:0] next_dir(input logic [1:0] dir);
    return dir + 2'd1;
  endfunction

endpackage

// File: rtl/traffic_control_unit_phase_timer.sv
// 8-bit loadable down-counter; saturates at zero and flags done while at zero.
module phase_timer
  import traffic_defs::*;
#(
  parameter logic [TIMER_W-1:0] RST_VAL = '0
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_load,
  input  logic [TIMER_W-1:0] i_load_val,
  output logic               o_done
);

  logic [TIMER_W-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= RST_VAL;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_done = (r_count == '0);

endmodule

// File: rtl/traffic_control_unit.sv
// Four-way intersection controller: round-robin greens separated by all-red
// clearance, with an emergency override that can hold or redirect the green.
module traffic_control_unit
  import traffic_defs::*;
#(
  parameter int GREEN_CYC  = 8,
  parameter int ALLRED_CYC = 2
) (
  input  logic       CU_CLK,
  input  logic       CU_Rst,
  input  logic [3:0] Req,
  input  logic       Emg,
  input  logic [1:0] Emg_Dir,
  output logic       CU_North,
  output logic       CU_East,
  output logic       CU_South,
  output logic       CU_West,
  output logic [1:0] Phase,
  output logic       Clear
);

  localparam logic [TIMER_W-1:0] GREEN_LOAD  = TIMER_W'(GREEN_CYC - 1);
  localparam logic [TIMER_W-1:0] ALLRED_LOAD = TIMER_W'(ALLRED_CYC - 1);

  state_t             r_state;
  state_t             w_state_next;
  logic [1:0]         r_phase;
  logic [1:0]         w_phase_next;
  logic [1:0]         w_rr_dir;
  logic [3:0]         r_sel;
  logic [3:0]         w_sel_next;
  logic               r_clear;
  logic               w_active;
  logic               w_load;
  logic [TIMER_W-1:0] w_load_val;
  logic               w_done;
  logic [1:0]         w_light [4];

  phase_timer #(
    .RST_VAL (ALLRED_LOAD)
  ) u_timer (
    .i_clk      (CU_CLK),
    .i_rst      (CU_Rst),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_done     (w_done)
  );

  // Scan from Phase+4 down to Phase+1 so the nearest requester after Phase wins;
  // Phase itself is reachable only when it is the sole requester.
  always_comb begin
    w_rr_dir = next_dir(r_phase);
    for (int k = 4; k >= 1; k--) begin
      if (Req[r_phase + 2'(k)]) w_rr_dir = r_phase + 2'(k);
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_phase_next = r_phase;
    w_load       = 1'b0;
    w_load_val   = ALLRED_LOAD;
    case (r_state)
      ST_CLEAR: begin
        if (w_done) begin
          if (Emg) begin
            w_state_next = ST_EMG;
            w_phase_next = Emg_Dir;
          end else begin
            w_state_next = ST_GREEN;
            w_phase_next = w_rr_dir;
            w_load       = 1'b1;
            w_load_val   = GREEN_LOAD;
          end
        end
      end
      ST_GREEN: begin
        if (Emg && Emg_Dir == r_phase) begin
          w_state_next = ST_EMG;
        end else if (Emg || w_done) begin
          w_state_next = ST_CLEAR;
          w_load       = 1'b1;
        end
      end
      ST_EMG: begin
        if (!Emg || Emg_Dir != r_phase) begin
          w_state_next = ST_CLEAR;
          w_load       = 1'b1;
        end
      end
      default: begin
        w_state_next = ST_CLEAR;
        w_load       = 1'b1;
      end
    endcase
  end

  assign w_active = (w_state_next != ST_CLEAR);

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_light
      assign w_light[gi]    = (w_active && w_phase_next == 2'(gi)) ? LIGHT_GREEN : LIGHT_RED;
      assign w_sel_next[gi] = (w_light[gi] == LIGHT_GREEN);
    end
  endgenerate

  // Outputs are registered from the next-state values so they follow the state
  // on the same edge; reset drops every green immediately.
  always_ff @(posedge CU_CLK or posedge CU_Rst) begin
    if (CU_Rst) begin
      r_state <= ST_CLEAR;
      r_phase <= DIR_W;
      r_sel   <= 4'b0000;
      r_clear <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_phase <= w_phase_next;
      r_sel   <= w_sel_next;
      r_clear <= !w_active;
    end
  end

  assign CU_North = r_sel[DIR_N];
  assign CU_East  = r_sel[DIR_E];
  assign CU_South = r_sel[DIR_S];
  assign CU_West  = r_sel[DIR_W];
  assign Phase    = r_phase;
  assign Clear    = r_clear;

endmodule

// File: tb/tb_traffic_control_unit.sv
// Directed scenarios for traffic_control_unit; stimulus queues per-cycle expected
// outputs, a negedge monitor pops and compares them.
module tb_traffic_control_unit;

  typedef struct {
    string      tag;
    logic [3:0] sel;
    logic [1:0] ph;
    logic       clr;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       emg;
  logic [1:0] emg_dir;
  logic       o_n, o_e, o_s, o_w;
  logic [1:0] o_phase;
  logic       o_clear;

  exp_t q[$];
  int   n_vec;
  int   n_err;

  traffic_control_unit #(
    .GREEN_CYC  (8),
    .ALLRED_CYC (2)
  ) dut (
    .CU_CLK   (clk),
    .CU_Rst   (rst),
    .Req      (req),
    .Emg      (emg),
    .Emg_Dir  (emg_dir),
    .CU_North (o_n),
    .CU_East  (o_e),
    .CU_South (o_s),
    .CU_West  (o_w),
    .Phase    (o_phase),
    .Clear    (o_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: one comparison per clock, sampled mid-cycle.
  initial begin
    exp_t       e;
    logic [3:0] act_sel;
    n_vec = 0;
    n_err = 0;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e       = q.pop_front();
        act_sel = {o_w, o_s, o_e, o_n};
        n_vec++;
        if (act_sel !== e.sel || o_phase !== e.ph || o_clear !== e.clr) begin
          n_err++;
          $display("FAIL %s vec%0d: sel=%b phase=%0d clear=%b, required sel=%b phase=%0d clear=%b",
                   e.tag, n_vec, act_sel, o_phase, o_clear, e.sel, e.ph, e.clr);
        end else begin
          $display("ok   %s vec%0d: sel=%b phase=%0d clear=%b", e.tag, n_vec, act_sel, o_phase, o_clear);
        end
      end
    end
  end

  task automatic step(input string tag, input logic [3:0] sel, input logic [1:0] ph, input logic clr);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.ph  = ph;
    e.clr = clr;
    q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic seg(input string tag, input int n, input logic [3:0] sel, input logic [1:0] ph,
                     input logic clr);
    repeat (n) step(tag, sel, ph, clr);
  endtask

  localparam logic [3:0] SN = 4'b0001;
  localparam logic [3:0] SE = 4'b0010;
  localparam logic [3:0] SS = 4'b0100;
  localparam logic [3:0] SW = 4'b1000;
  localparam logic [3:0] S0 = 4'b0000;

  initial begin
    rst     = 1'b1;
    req     = 4'b1111;
    emg     = 1'b0;
    emg_dir = 2'd0;
    @(posedge clk);
    #2;
    seg("reset_hold", 2, S0, 2'd3, 1'b1);
    rst = 1'b0;

    // All directions requesting: N,E,S,W each 8 green with 2 red between
    seg("rr_clear0", 2, S0, 2'd3, 1'b1);
    seg("rr_north", 8, SN, 2'd0, 1'b0);
    seg("rr_clear1", 2, S0, 2'd0, 1'b1);
    seg("rr_east", 8, SE, 2'd1, 1'b0);
    seg("rr_clear2", 2, S0, 2'd1, 1'b1);
    seg("rr_south", 8, SS, 2'd2, 1'b0);
    seg("rr_clear3", 2, S0, 2'd2, 1'b1);
    seg("rr_west", 8, SW, 2'd3, 1'b0);
    seg("rr_clear4", 2, S0, 2'd3, 1'b1);
    seg("rr_north2", 8, SN, 2'd0, 1'b0);

    // South only: South returns after its own clearance
    req = 4'b0100;
    seg("so_clear", 2, S0, 2'd0, 1'b1);
    seg("so_south", 8, SS, 2'd2, 1'b0);
    seg("so_clear2", 2, S0, 2'd2, 1'b1);
    seg("so_south2", 8, SS, 2'd2, 1'b0);

    // No requests: fixed-time fallback to Phase+1
    req = 4'b0000;
    seg("fb_clear", 2, S0, 2'd2, 1'b1);
    seg("fb_west", 8, SW, 2'd3, 1'b0);
    seg("fb_clear2", 2, S0, 2'd3, 1'b1);

    // Emergency to South during North green (cycle 3)
    seg("emg_n_pre", 2, SN, 2'd0, 1'b0);
    emg     = 1'b1;
    emg_dir = 2'd2;
    step("emg_n_abort", SN, 2'd0, 1'b0);
    seg("emg_clear", 2, S0, 2'd0, 1'b1);
    seg("emg_south", 5, SS, 2'd2, 1'b0);
    emg = 1'b0;
    step("emg_release", SS, 2'd2, 1'b0);
    seg("emg_clear2", 2, S0, 2'd2, 1'b1);
    seg("emg_west", 8, SW, 2'd3, 1'b0);
    seg("emg_clear3", 2, S0, 2'd3, 1'b1);

    // Emergency to North during North green: no red gap
    seg("hold_n_pre", 3, SN, 2'd0, 1'b0);
    emg     = 1'b1;
    emg_dir = 2'd0;
    seg("hold_n_emg", 7, SN, 2'd0, 1'b0);
    emg = 1'b0;
    step("hold_n_rel", SN, 2'd0, 1'b0);
    seg("hold_clear", 2, S0, 2'd0, 1'b1);

    // Asynchronous reset mid-East green
    seg("ar_east", 3, SE, 2'd1, 1'b0);
    rst = 1'b1;
    seg("ar_reset", 2, S0, 2'd3, 1'b1);
    rst = 1'b0;
    req = 4'b1111;
    seg("ar_clear", 2, S0, 2'd3, 1'b1);
    seg("ar_north", 8, SN, 2'd0, 1'b0);
    seg("ar_clear2", 2, S0, 2'd0, 1'b1);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      n_err++;
      $display("FAIL drain: %0d entries left, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/traffic_control_unit.md
TRAFFIC_CONTROL_UNIT -- requirements
Module: traffic_control_unit

Interface
REQ-001 Parameter GREEN_CYC, default 8, green duration in clock cycles (legal range 1..255).
REQ-002 Parameter ALLRED_CYC, default 2, all-red clearance duration in clock cycles (legal range 1..255).
REQ-003 CU_CLK  in  1  single clock; all state changes on its rising edge.
REQ-004 CU_Rst  in  1  asynchronous, active-high reset.
REQ-005 Req  in  4  vehicle-sensor requests, bit0=North, bit1=East, bit2=South, bit3=West; level-sensitive, sampled each edge.
REQ-006 Emg  in  1  emergency override request, level-sensitive.
REQ-007 Emg_Dir  in  2  emergency direction, 0=N, 1=E, 2=S, 3=W; sampled only when Emg=1.
REQ-008 CU_North, CU_East, CU_South, CU_West  out  1 each  datapath mux selects, 1=Green, 0=Red.
REQ-009 Phase  out  2  direction currently or last granted green, same encoding as Emg_Dir.
REQ-010 Clear  out  1  high while the FSM is in the all-red state CLEAR.

Function
REQ-011 The FSM SHALL have exactly three states: CLEAR (all red), GREEN (round-robin grant) and EMG (emergency grant).
REQ-012 All outputs SHALL be registered; a state entered at edge k SHALL drive its outputs from edge k.
REQ-013 In any cycle, at most one of CU_North/East/South/West SHALL be 1; in CLEAR, all four SHALL be 0.
REQ-014 On entering CLEAR or GREEN, the internal down-counter SHALL load (duration-1); the state SHALL last exactly ALLRED_CYC or GREEN_CYC cycles respectively.
REQ-015 CLEAR expiry with Emg=0 SHALL go to GREEN for the first direction with Req set, searching round-robin from Phase+1 (mod 4).
REQ-016 If Req==0 at CLEAR expiry, the next direction SHALL be Phase+1 (mod 4), a fixed-time fallback.
REQ-017 Phase SHALL update on entry to GREEN or EMG and SHALL hold its value through CLEAR.
REQ-018 GREEN expiry SHALL go to CLEAR; greens SHALL NOT be extended or terminated early by Req.
REQ-019 Emg=1 during GREEN with Emg_Dir==Phase SHALL move to EMG on the next edge, keeping the same green with no red gap.
REQ-020 Emg=1 during GREEN with Emg_Dir!=Phase SHALL abort GREEN into CLEAR on the next edge.
REQ-021 CLEAR expiry with Emg=1 SHALL go to EMG granting Emg_Dir; a CLEAR already in progress SHALL always run to full length.
REQ-022 EMG SHALL hold the Emg_Dir green while Emg=1.
REQ-023 A change of Emg_Dir during EMG SHALL transition EMG -> CLEAR -> EMG(new direction).
REQ-024 Emg deassertion in EMG SHALL go to CLEAR; round-robin SHALL then resume from Phase+1.
REQ-025 Two different directions SHALL never be green without at least ALLRED_CYC all-red cycles between them.
REQ-026 The counter SHALL be 8 bits wide and SHALL never wrap below zero; expiry is counter==0 in the current state.

Reset
REQ-027 While CU_Rst=1, outputs SHALL be: state=CLEAR, counter=ALLRED_CYC-1, Phase=3 (West), Clear=1, all four selects 0.
REQ-028 Reset assertion mid-GREEN or mid-EMG SHALL force all selects to 0 asynchronously, without waiting for a clock edge.
REQ-029 After reset release, the first green SHALL follow ALLRED_CYC cycles of CLEAR and SHALL go to North if Req[0]=1.

Structure
REQ-030 A shared header traffic_defs SHALL hold the direction codes (N=0, E=1, S=2, W=3), the state encodings and the Green/Red codes 2'b01/2'b10.
REQ-031 A single sub-module, phase_timer (8-bit loadable down-counter with load and done signals), SHALL implement the duration counter.
REQ-032 Round-robin selection SHALL be combinational logic inside traffic_control_unit.

Verification (GREEN_CYC=8, ALLRED_CYC=2)
REQ-033 Reset, then Req=4'b1111 -> 2 cycles all red, then N, E, S, W each green 8 cycles with 2 red cycles between; repeats N after W.
REQ-034 Req=4'b0100 only -> after the first clearance, South green 8 cycles, CLEAR 2 cycles, South again; North/East/West stay 0.
REQ-035 Req=0 -> N, E, S, W sequence proceeds under the fixed-time fallback; Clear=1 for exactly 2 cycles between greens.
REQ-036 Emg=1, Emg_Dir=2 asserted in cycle 3 of the North green -> next edge CLEAR for 2 cycles, then CU_South=1 held until Emg=0, then CLEAR 2 cycles, then West green.
REQ-037 Emg=1, Emg_Dir=0 during the North green -> CU_North stays 1 continuously with no red gap; on Emg=0, CLEAR then East.
REQ-038 CU_Rst pulsed asynchronously mid-East-green -> selects go 0 before the next edge; after release, 2 red cycles then North green.
